// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the TX capture sequencer: FSM state
// encoding, word packing geometry and the filled-lanes byteenable helper.
package tx_ctrl_pkg;

    localparam int SYMS_PER_WORD = 4;
    localparam int WORD_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Lanes fill from bit 0 upward, so N filled lanes map to the N low mask bits.
    function automatic logic [SYMS_PER_WORD-1:0] lane_mask(input logic [2:0] filled_lanes);
        logic [SYMS_PER_WORD-1:0] m;
        m = '0;
        for (int i = 0; i < SYMS_PER_WORD; i++) begin
            if (int'(filled_lanes) > i) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tx_capture_sequencer_if.sv
// s1 write port of the on-chip capture memory (no wait-states, write-only
// from the sequencer side).
interface tx_capture_sequencer_if
    import tx_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0]        mem_address;
    logic                     mem_chipselect;
    logic                     mem_clken;
    logic                     mem_write;
    logic [WORD_W-1:0]        mem_writedata;
    logic [SYMS_PER_WORD-1:0] mem_byteenable;

    modport master (
        output mem_address,
        output mem_chipselect,
        output mem_clken,
        output mem_write,
        output mem_writedata,
        output mem_byteenable
    );

    modport slave (
        input mem_address,
        input mem_chipselect,
        input mem_clken,
        input mem_write,
        input mem_writedata,
        input mem_byteenable
    );
endinterface

// File: rtl/tx_word_packer.sv
// Packs PAM levels four per word. Exposes the word, lane count and byteenable
// as they would look after the current symbol is accepted.
module tx_word_packer
    import tx_ctrl_pkg::*;
#(
    parameter int LVL_W = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     clear,
    input  logic                     accept,
    input  logic [LVL_W-1:0]         level,
    output logic [WORD_W-1:0]        word,
    output logic [2:0]               filled,
    output logic [SYMS_PER_WORD-1:0] mask
);

    logic [WORD_W-1:0] lanes_reg;
    logic [1:0]        lane_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYMS_PER_WORD; gi++) begin : g_lane
            assign word[gi*LVL_W +: LVL_W] = (accept && (lane_reg == 2'(gi)))
                                           ? level
                                           : lanes_reg[gi*LVL_W +: LVL_W];
        end
    endgenerate

    assign filled = {1'b0, lane_reg} + {2'b00, accept};
    assign mask   = lane_mask(filled);

    // A completed word leaves with the write, so the lanes restart from zero
    // and any later partial word has zeros in its unfilled lanes.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            lanes_reg <= '0;
            lane_reg  <= '0;
        end else if (accept) begin
            lane_reg  <= lane_reg + 2'd1;
            lanes_reg <= (lane_reg == 2'd3) ? '0 : word;
        end
    end

endmodule

// File: rtl/tx_capture_sequencer.sv
// Runs the PRBS/PAM chain for a programmed symbol count and streams the packed
// levels into the capture memory; FSM, symbol counter and write address.
module tx_capture_sequencer
    import tx_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LVL_W  = 8,
    parameter int CNT_W  = ADDR_W + 2
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNT_W-1:0]       num_symbols,
    input  logic [LVL_W-1:0]       level_in,
    input  logic                   level_valid,
    output logic                   prbs_en,
    tx_capture_sequencer_if.master mem,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sym_count
);

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         target_reg, target_next;
    logic [CNT_W-1:0]         count_reg, count_next;
    logic [ADDR_W-1:0]        addr_reg, addr_next;
    logic                     wr_next;
    logic [WORD_W-1:0]        wdata_next;
    logic [SYMS_PER_WORD-1:0] be_next;
    logic                     accept;
    logic                     pack_clear;
    logic                     srst;
    logic [WORD_W-1:0]        pk_word;
    logic [2:0]               pk_filled;
    logic [SYMS_PER_WORD-1:0] pk_mask;

    assign srst      = ~reset_reset_n;
    assign sym_count = count_reg;

    tx_word_packer #(
        .LVL_W (LVL_W)
    ) u_packer (
        .clk    (clk_clk),
        .srst   (srst),
        .clear  (pack_clear),
        .accept (accept),
        .level  (level_in),
        .word   (pk_word),
        .filled (pk_filled),
        .mask   (pk_mask)
    );

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        count_next  = count_reg;
        addr_next   = addr_reg;
        wr_next     = 1'b0;
        wdata_next  = '0;
        be_next     = '0;
        accept      = 1'b0;
        pack_clear  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    count_next = '0;
                    if (num_symbols != '0) begin
                        target_next = num_symbols;
                        addr_next   = '0;
                        pack_clear  = 1'b1;
                        state_next  = ST_RUN;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                accept = level_valid;
                if (level_valid) begin
                    count_next = count_reg + CNT_W'(1);
                end
                if ((level_valid && (count_next == target_reg)) || abort) begin
                    state_next = ST_FLUSH;
                end
                // A full word always goes out; a partial one only on the way to FLUSH,
                // so the flush write shares the cycle with the last RUN write slot.
                if ((pk_filled == 3'd4) || ((state_next == ST_FLUSH) && (pk_filled != 3'd0))) begin
                    wr_next    = 1'b1;
                    wdata_next = pk_word;
                    be_next    = pk_mask;
                    addr_next  = addr_reg + ADDR_W'(1);
                end
            end
            ST_FLUSH: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_reg          <= ST_IDLE;
            target_reg         <= '0;
            count_reg          <= '0;
            addr_reg           <= '0;
            prbs_en            <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            mem.mem_address    <= '0;
            mem.mem_chipselect <= 1'b0;
            mem.mem_clken      <= 1'b0;
            mem.mem_write      <= 1'b0;
            mem.mem_writedata  <= '0;
            mem.mem_byteenable <= '0;
        end else begin
            state_reg          <= state_next;
            target_reg         <= target_next;
            count_reg          <= count_next;
            addr_reg           <= addr_next;
            prbs_en            <= (state_next == ST_RUN);
            busy               <= (state_next == ST_RUN) || (state_next == ST_FLUSH);
            done               <= (state_next == ST_DONE);
            mem.mem_chipselect <= wr_next;
            mem.mem_clken      <= wr_next;
            mem.mem_write      <= wr_next;
            mem.mem_writedata  <= wdata_next;
            mem.mem_byteenable <= be_next;
            if (wr_next) begin
                mem.mem_address <= addr_reg;
            end
        end
    end

endmodule
